// File: rtl/edge_event_arbiter.sv
// Per-channel edge detector with pending-event latches, served one event at a
// time to a single consumer by a round-robin arbiter over valid/ready.
module edge_event_arbiter #(
   parameter  int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [N-1:0]   level,
   input  logic [N-1:0]   pos_en,
   input  logic [N-1:0]   neg_en,
   output logic           evt_valid,
   input  logic           evt_ready,
   output logic [IDW-1:0] evt_id,
   output logic           evt_pol,
   output logic [N-1:0]   overflow,
   input  logic           ovf_clr
);

   // Handshake: an event transfers on a clock where evt_valid and evt_ready are
   // both high; evt_id/evt_pol stay stable while evt_valid is high and unaccepted.
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic [N-1:0]   prev_level;
   logic [N-1:0]   pending;
   logic [N-1:0]   pend_pol;
   logic [N-1:0]   overflow_r;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] id_r;
   logic           pol_r;

   logic [N-1:0]   rise;
   logic [N-1:0]   fall;
   logic [N-1:0]   edge_det;
   logic [N-1:0]   acc_vec;
   logic [N-1:0]   ovf_set;
   logic [IDW-1:0] sel;
   logic           any_pending;
   logic           accept;
   logic           grant;
   int             rr_idx;

   assign rise        = ~prev_level & level & pos_en;
   assign fall        = prev_level & ~level & neg_en;
   assign edge_det    = rise | fall;
   assign any_pending = |pending;
   assign accept      = (state == HOLD) && evt_ready;
   assign grant       = (state == IDLE) && any_pending;

   always_comb begin
      acc_vec = '0;
      for (int i = 0; i < N; i++) begin
         acc_vec[i] = accept && (id_r == IDW'(i));
      end
   end

   // A new edge on a channel already pending is lost unless that channel is
   // being accepted in the same cycle, in which case it simply replaces it.
   assign ovf_set = edge_det & pending & ~acc_vec;

   // Search starts just after the last granted channel and wraps around.
   always_comb begin
      sel    = '0;
      rr_idx = 0;
      for (int k = N; k >= 1; k--) begin
         rr_idx = (int'(last_grant) + k) % N;
         if (pending[rr_idx]) begin
            sel = IDW'(rr_idx);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (any_pending) state_nxt = HOLD;
         HOLD: if (evt_ready)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_level <= '0;
         pending    <= '0;
         pend_pol   <= '0;
      end else begin
         prev_level <= level;
         for (int i = 0; i < N; i++) begin
            if (edge_det[i]) begin
               if (!pending[i] || acc_vec[i]) begin
                  pending[i]  <= 1'b1;
                  pend_pol[i] <= rise[i];
               end
            end else if (acc_vec[i]) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_r <= '0;
      end else begin
         overflow_r <= (ovf_clr ? '0 : overflow_r) | ovf_set;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         id_r       <= '0;
         pol_r      <= 1'b0;
         last_grant <= IDW'(N - 1);
      end else begin
         if (grant) begin
            id_r  <= sel;
            pol_r <= pend_pol[sel];
         end
         if (accept) begin
            last_grant <= id_r;
         end
      end
   end

   assign evt_valid = (state == HOLD);
   assign evt_id    = id_r;
   assign evt_pol   = pol_r;
   assign overflow  = overflow_r;

endmodule
